// File: rtl/mips_defs_pkg.sv
// Shared MIPS datapath definitions: widths, architectural register indices,
// stack-pointer reset value and the read-port bypass enable.
package mips_defs;
   localparam int          DATA_W    = 32;
   localparam int          ADDR_W    = 5;
   localparam logic [4:0]  REG_ZERO  = 5'd0;
   localparam logic [4:0]  REG_SP    = 5'd29;
   localparam logic [31:0] SP_INIT   = 32'h0000_03FC;
   localparam bit          BYPASS_EN = 1'b1;
endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: register-0 forcing, write-through compare and
// the final select between bypass data and stored data.
module reg_read_port
   import mips_defs::*;
#(
   parameter int DATA_W    = mips_defs::DATA_W,
   parameter int ADDR_W    = mips_defs::ADDR_W,
   parameter bit BYPASS_EN = mips_defs::BYPASS_EN
) (
   input  logic [ADDR_W-1:0] read_addr,
   input  logic              bypass_valid,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] stored_data,
   output logic [DATA_W-1:0] data
);

   // Register 0 outranks the bypass so a discarded write can never leak through.
   always_comb begin
      data = stored_data;
      if (read_addr == ADDR_W'(REG_ZERO)) begin
         data = '0;
      end else if (BYPASS_EN && bypass_valid && (write_addr == read_addr)) begin
         data = write_data;
      end
   end

endmodule

// File: rtl/reg_file.sv
// Two-read/one-write general-purpose register file with hardwired zero
// register, programmable $sp reset value and a saturating write counter.
module reg_file
   import mips_defs::*;
#(
   parameter int                        DATA_W  = mips_defs::DATA_W,
   parameter int                        ADDR_W  = mips_defs::ADDR_W,
   parameter logic [mips_defs::DATA_W-1:0] SP_INIT = mips_defs::SP_INIT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] read_addr_a,
   input  logic [ADDR_W-1:0] read_addr_b,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] data_a,
   output logic [DATA_W-1:0] data_b,
   output logic [15:0]       write_count
);

   localparam int unsigned NUM_REGS = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              write_valid;
   logic              bypass_valid;

   assign write_valid  = write_enable && (write_addr != ADDR_W'(REG_ZERO));
   // Bypass is suppressed under reset so the ports show the cleared file.
   assign bypass_valid = write_valid && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         regs[ADDR_W'(REG_SP)] <= DATA_W'(SP_INIT);
         write_count           <= '0;
      end else if (write_valid) begin
         regs[write_addr] <= write_data;
         if (write_count != '1) begin
            write_count <= write_count + 16'd1;
         end
      end
   end

   reg_read_port #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .BYPASS_EN (BYPASS_EN)
   ) u_port_a (
      .read_addr    (read_addr_a),
      .bypass_valid (bypass_valid),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .stored_data  (regs[read_addr_a]),
      .data         (data_a)
   );

   reg_read_port #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .BYPASS_EN (BYPASS_EN)
   ) u_port_b (
      .read_addr    (read_addr_b),
      .bypass_valid (bypass_valid),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .stored_data  (regs[read_addr_b]),
      .data         (data_b)
   );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected port values, a
// negedge monitor pops and compares them against the DUT.
module tb_reg_file;

   localparam logic [31:0] SP_VAL = 32'h0000_03FC;

   logic        clk;
   logic        reset;
   logic [4:0]  read_addr_a;
   logic [4:0]  read_addr_b;
   logic        write_enable;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [31:0] data_a;
   logic [31:0] data_b;
   logic [15:0] write_count;

   reg_file #(
      .DATA_W  (32),
      .ADDR_W  (5),
      .SP_INIT (SP_VAL)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .read_addr_a  (read_addr_a),
      .read_addr_b  (read_addr_b),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .data_a       (data_a),
      .data_b       (data_b),
      .write_count  (write_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [15:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model [32];
   int unsigned m_cnt;
   int          checks = 0;
   int          errors = 0;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) model[i] = (i == 29) ? SP_VAL : 32'd0;
      m_cnt = 0;
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] ra, input bit rst,
                                              input bit we, input logic [4:0] wa,
                                              input logic [31:0] wd);
      if (ra == 5'd0) return 32'd0;
      if (!rst && we && wa != 5'd0 && wa == ra) return wd;
      return model[ra];
   endfunction

   // Called one time unit after a rising edge; returns at the same phase of the next cycle.
   task automatic step(input bit rst, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                       input bit chk, input string nm);
      exp_t e;
      reset        = rst;
      write_enable = we;
      write_addr   = wa;
      write_data   = wd;
      read_addr_a  = ra;
      read_addr_b  = rb;
      if (rst) model_reset();
      if (chk) begin
         e.name = nm;
         e.a    = model_read(ra, rst, we, wa, wd);
         e.b    = model_read(rb, rst, we, wa, wd);
         e.cnt  = 16'(m_cnt);
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (!rst && we && wa != 5'd0) begin
         model[wa] = wd;
         if (m_cnt < 32'hFFFF) m_cnt++;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (data_a !== e.a) begin
            errors++;
            $display("FAIL %s data_a: got %h expected %h", e.name, data_a, e.a);
         end
         checks++;
         if (data_b !== e.b) begin
            errors++;
            $display("FAIL %s data_b: got %h expected %h", e.name, data_b, e.b);
         end
         checks++;
         if (write_count !== e.cnt) begin
            errors++;
            $display("FAIL %s write_count: got %h expected %h", e.name, write_count, e.cnt);
         end
      end
   end

   initial begin
      logic [4:0]  wa, ra, rb;
      logic [31:0] wd;
      bit          we, rst;

      reset = 1'b1; write_enable = 1'b0; write_addr = '0; write_data = '0;
      read_addr_a = '0; read_addr_b = '0;
      model_reset();
      @(posedge clk);
      #1;

      // Reset state
      step(1, 0, 5'd0, 32'd0, 5'd0, 5'd5, 1, "reset_0_5");
      step(1, 0, 5'd0, 32'd0, 5'd29, 5'd5, 1, "reset_29");
      step(0, 0, 5'd0, 32'd0, 5'd29, 5'd0, 1, "post_reset");

      // Write then read
      step(0, 1, 5'd7, 32'hDEAD_BEEF, 5'd1, 5'd2, 0, "");
      step(0, 0, 5'd0, 32'd0, 5'd7, 5'd7, 1, "write_read_7");

      // Register 0 write is discarded, both in the bypass cycle and afterwards
      step(0, 1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 1, "zero_bypass");
      step(0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 1, "zero_after");

      // Bypass
      step(0, 1, 5'd3, 32'h1111, 5'd0, 5'd0, 0, "");
      step(0, 1, 5'd4, 32'h4444, 5'd0, 5'd0, 0, "");
      step(0, 1, 5'd3, 32'h2222, 5'd3, 5'd4, 1, "bypass_a");
      step(0, 1, 5'd4, 32'h5555, 5'd4, 5'd4, 1, "bypass_both");
      step(0, 0, 5'd0, 32'd0, 5'd3, 5'd4, 1, "after_bypass");

      // Reset while a write to 9 is pending; an edge passes with reset high
      step(0, 1, 5'd10, 32'hAAAA_0010, 5'd0, 5'd0, 0, "");
      step(0, 1, 5'd11, 32'hAAAA_0011, 5'd10, 5'd11, 1, "pre_rst");
      step(1, 1, 5'd9, 32'h9999_9999, 5'd9, 5'd29, 1, "rst_mid_write");
      step(0, 0, 5'd0, 32'd0, 5'd9, 5'd10, 1, "rst_after_9");
      step(0, 1, 5'd9, 32'h0900_0009, 5'd11, 5'd29, 1, "first_write");
      step(0, 0, 5'd0, 32'd0, 5'd9, 5'd11, 1, "first_write_rd");

      // Randomized traffic with bypass-biased addresses and occasional resets
      for (int i = 0; i < 400; i++) begin
         we  = ($urandom_range(0, 3) != 0);
         wa  = 5'($urandom_range(0, 31));
         wd  = $urandom;
         ra  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         rb  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         rst = ($urandom_range(0, 63) == 0);
         step(rst, we, wa, wd, ra, rb, 1, "random");
      end

      // Saturation of write_count
      step(1, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0, "");
      for (int i = 0; i < 70000; i++) begin
         step(0, 1, 5'd1, $urandom, 5'd1, 5'd0,
              (i % 10000 == 0) || (i >= 65530 && i <= 65540) || (i >= 69995), "saturate");
      end
      step(0, 1, 5'd2, 32'h0202_0202, 5'd1, 5'd2, 1, "sat_hold");
      step(0, 0, 5'd0, 32'd0, 5'd2, 5'd1, 1, "sat_final");

      write_enable = 1'b0;
      for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
